// File: rtl/elevator_pkg.sv
// elevator_pkg: shared controller states, travel direction and default sizing.
package elevator_pkg;
    localparam int DEF_NUM_FLOORS = 40;
    localparam int DEF_FLOOR_W = 6;
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
    typedef enum logic {UP, DOWN} dir_t;
endpackage

// File: rtl/elevator_scan_ctrl_if.sv
// elevator_scan_ctrl_if: call-button requests in, car/door/display status out.
interface elevator_scan_ctrl_if #(
    parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
    parameter int FLOOR_W = elevator_pkg::DEF_FLOOR_W
);
    logic req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic [FLOOR_W-1:0] current_floor;
    logic moving_up;
    logic moving_down;
    logic door_open;
    logic arrived;
    logic [NUM_FLOORS-1:0] pending;
    logic req_err;
    modport master (
        output req_valid, req_floor,
        input current_floor, moving_up, moving_down, door_open, arrived, pending, req_err
    );
    modport slave (
        input req_valid, req_floor,
        output current_floor, moving_up, moving_down, door_open, arrived, pending, req_err
    );
endinterface

// File: rtl/elevator_call_scan.sv
// elevator_call_scan: classifies outstanding calls relative to the car position.
module elevator_call_scan #(
    parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
    parameter int FLOOR_W = elevator_pkg::DEF_FLOOR_W
) (
    input logic [NUM_FLOORS-1:0] pending,
    input logic [FLOOR_W-1:0] current_floor,
    output logic any_above,
    output logic any_below,
    output logic here
);
    logic [NUM_FLOORS-1:0] at_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    assign at_mask = NUM_FLOORS'(1) << current_floor;
    assign below_mask = at_mask - NUM_FLOORS'(1);
    assign here = |(pending & at_mask);
    assign any_below = |(pending & below_mask);
    assign any_above = |(pending & ~(below_mask | at_mask));
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN-policy elevator controller with timed travel and door dwell.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W = DEF_FLOOR_W,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES = 16
) (
    input logic clk,
    input logic reset,
    elevator_scan_ctrl_if.slave bus
);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

    state_t state, state_n;
    dir_t last_dir, last_dir_n;
    logic [FLOOR_W-1:0] cur, cur_n;
    logic [NUM_FLOORS-1:0] pending, set_mask, clr_mask;
    logic [TW-1:0] travel_cnt, travel_n;
    logic [DW-1:0] door_cnt, door_n;
    logic arrived, arrived_n, req_err;
    logic any_above, any_below, here;
    logic in_range, door_hold, travel_tc, door_tc, go_up, go_dn, decide;

    elevator_call_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) scan (
        .pending(pending),
        .current_floor(cur),
        .any_above(any_above),
        .any_below(any_below),
        .here(here)
    );

    assign in_range = int'(bus.req_floor) < NUM_FLOORS;
    // A call for the floor whose door is open just extends the dwell.
    assign door_hold = state == DOOR_OPEN && bus.req_valid && bus.req_floor == cur;
    assign set_mask = (bus.req_valid && in_range && !door_hold) ? NUM_FLOORS'(1) << bus.req_floor : '0;
    assign travel_tc = travel_cnt == TRAVEL_LAST;
    assign door_tc = door_cnt == DOOR_LAST;
    // Keep heading the way we last travelled while calls remain that way.
    assign go_up = any_above && (last_dir == UP || !any_below);
    assign go_dn = any_below && !go_up;

    always_comb begin
        state_n = state;
        last_dir_n = last_dir;
        cur_n = cur;
        travel_n = '0;
        door_n = '0;
        clr_mask = '0;
        arrived_n = 1'b0;
        decide = 1'b0;
        case (state)
            IDLE: decide = 1'b1;
            MOVE_UP, MOVE_DOWN: begin
                travel_n = travel_tc ? '0 : travel_cnt + TW'(1);
                if (travel_tc) begin
                    cur_n = state == MOVE_UP ? (cur == TOP ? cur : cur + FLOOR_W'(1))
                                             : (cur == '0 ? cur : cur - FLOOR_W'(1));
                    if (|(pending & (NUM_FLOORS'(1) << cur_n))) begin
                        state_n = DOOR_OPEN;
                        clr_mask = NUM_FLOORS'(1) << cur_n;
                        arrived_n = 1'b1;
                    end
                end
            end
            DOOR_OPEN: begin
                door_n = door_hold ? '0 : door_cnt + DW'(1);
                decide = !door_hold && door_tc;
            end
            default: state_n = IDLE;
        endcase
        if (decide) begin
            door_n = '0;
            state_n = here ? DOOR_OPEN : go_up ? MOVE_UP : go_dn ? MOVE_DOWN : IDLE;
            last_dir_n = here ? last_dir : go_up ? UP : go_dn ? DOWN : last_dir;
            clr_mask = here ? NUM_FLOORS'(1) << cur : '0;
            arrived_n = here;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last_dir <= UP;
            cur <= '0;
            pending <= '0;
            travel_cnt <= '0;
            door_cnt <= '0;
            arrived <= 1'b0;
            req_err <= 1'b0;
        end else begin
            state <= state_n;
            last_dir <= last_dir_n;
            cur <= cur_n;
            pending <= (pending | set_mask) & ~clr_mask;
            travel_cnt <= travel_n;
            door_cnt <= door_n;
            arrived <= arrived_n;
            req_err <= bus.req_valid && !in_range;
        end
    end

    // SCAN only travels toward an outstanding call, so hitting a bound means lost state.
    assert property (@(posedge clk) disable iff (reset) !(state == MOVE_UP && travel_tc && cur == TOP));
    assert property (@(posedge clk) disable iff (reset) !(state == MOVE_DOWN && travel_tc && cur == '0));

    assign bus.current_floor = cur;
    assign bus.moving_up = state == MOVE_UP;
    assign bus.moving_down = state == MOVE_DOWN;
    assign bus.door_open = state == DOOR_OPEN;
    assign bus.arrived = arrived;
    assign bus.pending = pending;
    assign bus.req_err = req_err;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: scenario bench; expected stop floors are queued when calls are issued.
module tb_elevator_scan_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int exp_q[$];

    elevator_scan_ctrl_if #(.NUM_FLOORS(40), .FLOOR_W(6)) bus ();

    elevator_scan_ctrl #(
        .NUM_FLOORS(40), .FLOOR_W(6), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int f);
        bus.req_valid = 1'b1;
        bus.req_floor = 6'(f);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_arrive(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = bus.arrived;
        end
        check(tag, 64'(seen), 1);
    endtask

    task automatic wait_floor(input string tag, input int f);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = int'(bus.current_floor) == f;
        end
        check(tag, 64'(seen), 1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = !(bus.moving_up || bus.moving_down || bus.door_open);
        end
        check(tag, 64'(seen), 1);
    endtask

    // Scoreboard: every arrival pulse must match the next queued stop floor.
    always @(negedge clk) begin
        if (!reset && bus.arrived) begin
            check("arrive_door", 64'(bus.door_open), 1);
            if (exp_q.size() > 0) check("arrive_floor", 64'(bus.current_floor), 64'(exp_q.pop_front()));
            else check("arrive_unexpected", 64'(exp_q.size()), 1);
        end
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
        repeat (2) tick();
        check("rst_floor", 64'(bus.current_floor), 0);
        check("rst_pending", 64'(bus.pending), 0);
        check("rst_flags", 64'({bus.moving_up, bus.moving_down, bus.door_open, bus.arrived, bus.req_err}), 0);

        // Single trip to floor 3 with exact cycle timing.
        reset = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_floor = 6'd3;
        exp_q.push_back(3);
        for (int c = 1; c <= 17; c++) begin
            tick();
            bus.req_valid = 1'b0;
            if (c == 1) check("t1_pending", 64'(bus.pending), 8);
            check("t1_floor", 64'(bus.current_floor), c < 6 ? 0 : c < 10 ? 1 : c < 14 ? 2 : 3);
            check("t1_up", 64'(bus.moving_up), 64'(c >= 2 && c < 14));
            check("t1_door", 64'(bus.door_open), 64'(c >= 14 && c <= 16));
        end
        check("t1_pending_end", 64'(bus.pending), 0);

        // Up to 9 with a call at 2 behind; then door-time calls 4 and 0 keep direction down.
        drive_req(9);
        exp_q.push_back(9);
        wait_floor("t2_at5", 5);
        check("t2_up5", 64'(bus.moving_up), 1);
        exp_q.push_back(2);
        drive_req(2);
        wait_arrive("t2_arr9");
        repeat (3) tick();
        check("t2_reverse", 64'(bus.moving_down), 1);
        wait_arrive("t2_arr2");
        exp_q.push_back(0);
        exp_q.push_back(4);
        drive_req(4);
        drive_req(0);
        tick();
        check("t2_keep_down", 64'(bus.moving_down), 1);
        wait_arrive("t2_arr0");
        wait_arrive("t2_arr4");
        wait_idle("t2_idle");

        // Call at 7 picked up while passing on the way to 9.
        drive_req(9);
        wait_floor("t3_at5", 5);
        repeat (2) tick();
        exp_q.push_back(7);
        exp_q.push_back(9);
        drive_req(7);
        wait_arrive("t3_arr7");
        check("t3_floor7", 64'(bus.current_floor), 7);
        check("t3_pending", 64'(bus.pending), 64'd512);
        wait_arrive("t3_arr9");
        wait_idle("t3_idle");

        // Door extension at floor 3.
        exp_q.push_back(3);
        drive_req(3);
        wait_arrive("t4_arr3");
        repeat (2) tick();
        drive_req(3);
        for (int d = 3; d <= 6; d++) begin
            check("t4_door", 64'(bus.door_open), 64'(d < 6));
            check("t4_pending", 64'(bus.pending), 0);
            if (d < 6) tick();
        end

        // Out-of-range call.
        drive_req(45);
        check("t5_err", 64'(bus.req_err), 1);
        check("t5_pending", 64'(bus.pending), 0);
        check("t5_floor", 64'(bus.current_floor), 3);
        check("t5_state", 64'({bus.moving_up, bus.moving_down, bus.door_open}), 0);
        tick();
        check("t5_err_pulse", 64'(bus.req_err), 0);

        // Reset while moving down, then normal service.
        exp_q.push_back(14);
        drive_req(14);
        wait_arrive("t6_arr14");
        wait_idle("t6_idle14");
        exp_q.push_back(0);
        drive_req(0);
        wait_floor("t6_at12", 12);
        check("t6_down", 64'(bus.moving_down), 1);
        reset = 1'b1;
        tick();
        exp_q.delete();
        check("t6_rst_floor", 64'(bus.current_floor), 0);
        check("t6_rst_pending", 64'(bus.pending), 0);
        check("t6_rst_flags", 64'({bus.moving_up, bus.moving_down, bus.door_open, bus.arrived, bus.req_err}), 0);
        reset = 1'b0;
        exp_q.push_back(2);
        drive_req(2);
        check("t6_pending", 64'(bus.pending), 4);
        wait_arrive("t6_arr2");
        wait_idle("t6_idle2");

        check("queue_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
